// File: rtl/synth_pkg.sv
// Shared types for the frequency source scheduler.
// Note pair layout matches the song ROM word.
package synth_pkg;

   localparam int FREQ_W = 11;

   typedef logic [FREQ_W-1:0] freq_t;

   typedef struct packed {
      freq_t f1;
      freq_t f2;
   } note_pair_t;

   typedef enum logic [2:0] {
      IDLE,
      C_FETCH,
      C_LOAD,
      C_PLAY,
      HUMAN,
      HOLDOFF
   } sched_state_t;

   function automatic logic is_computer(sched_state_t s);
      return (s == C_FETCH) || (s == C_LOAD) || (s == C_PLAY);
   endfunction

endpackage

// File: rtl/freq_source_scheduler_tick_counter.sv
// Clearable beat-tick counter with terminal-count strobe.
// Wraps to zero on terminal tick so it never exceeds TERM-1.
module tick_counter #(
   parameter int TERM = 8,
   parameter int W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic tick,
   output logic done
);

   logic [W-1:0] cnt;

   assign done = en && tick && (cnt == W'(TERM - 1));

   // count enabled ticks, clear on reset or request
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en && tick) begin
         cnt <= done ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/freq_source_scheduler.sv
// Human/computer frequency mux controller with song playback.
// Human keys preempt playback; playback resumes after a hold-off.
module freq_source_scheduler
   import synth_pkg::*;
#(
   parameter int ADDR_W        = 6,
   parameter int SONG_LEN      = 32,
   parameter int NOTE_TICKS    = 8,
   parameter int HOLDOFF_TICKS = 4,
   parameter int LOOP          = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              h_active,
   input  logic              autoplay_en,
   input  logic              tick,
   input  logic [21:0]       rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              select,
   output logic [10:0]       c_freq1,
   output logic [10:0]       c_freq2,
   output logic              playing
);

   localparam int MAXT  = (NOTE_TICKS > HOLDOFF_TICKS) ?
                          NOTE_TICKS : HOLDOFF_TICKS;
   localparam int CNT_W = $clog2(MAXT + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SONG_LEN - 1);

   sched_state_t      state;
   sched_state_t      state_n;
   logic [ADDR_W-1:0] addr_n;
   freq_t             f1_n;
   freq_t             f2_n;
   note_pair_t        rom_pair;
   logic              step_done;
   logic              hold_done;

   assign rom_pair = rom_data;

   tick_counter #(
      .TERM (NOTE_TICKS),
      .W    (CNT_W)
   ) u_step (
      .clk   (Clk),
      .reset (Reset),
      .clr   (state != C_PLAY),
      .en    (state == C_PLAY),
      .tick  (tick),
      .done  (step_done)
   );

   tick_counter #(
      .TERM (HOLDOFF_TICKS),
      .W    (CNT_W)
   ) u_hold (
      .clk   (Clk),
      .reset (Reset),
      .clr   (state != HOLDOFF),
      .en    (state == HOLDOFF),
      .tick  (tick),
      .done  (hold_done)
   );

   // state and registered outputs, all derived from the next state
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         rom_addr <= '0;
         c_freq1  <= '0;
         c_freq2  <= '0;
         select   <= 1'b0;
         playing  <= 1'b0;
      end else begin
         state    <= state_n;
         rom_addr <= addr_n;
         c_freq1  <= f1_n;
         c_freq2  <= f2_n;
         select   <= is_computer(state_n);
         playing  <= (state_n == C_PLAY);
      end
   end

   // next state, next address and next note
   always_comb begin
      state_n = state;
      addr_n  = rom_addr;
      f1_n    = c_freq1;
      f2_n    = c_freq2;
      unique case (state)
         IDLE: begin
            if (h_active) begin
               state_n = HUMAN;
            end else if (autoplay_en) begin
               state_n = C_FETCH;
            end
         end
         C_FETCH, C_LOAD, C_PLAY: begin
            if (h_active) begin
               state_n = HUMAN;
            end else if (!autoplay_en) begin
               state_n = IDLE;
               addr_n  = '0;
               f1_n    = '0;
               f2_n    = '0;
            end else if (state == C_FETCH) begin
               state_n = C_LOAD;
            end else if (state == C_LOAD) begin
               state_n = C_PLAY;
               f1_n    = rom_pair.f1;
               f2_n    = rom_pair.f2;
            end else if (step_done) begin
               if (rom_addr < LAST) begin
                  state_n = C_FETCH;
                  addr_n  = rom_addr + ADDR_W'(1);
               end else if (LOOP != 0) begin
                  state_n = C_FETCH;
                  addr_n  = '0;
               end else begin
                  state_n = IDLE;
                  addr_n  = '0;
                  f1_n    = '0;
                  f2_n    = '0;
               end
            end
         end
         HUMAN: begin
            if (!h_active) begin
               state_n = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (h_active) begin
               state_n = HUMAN;
            end else if (hold_done) begin
               if (autoplay_en) begin
                  state_n = C_FETCH;
               end else begin
                  state_n = IDLE;
                  addr_n  = '0;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_freq_source_scheduler.sv
// Scoreboard bench for freq_source_scheduler.
// Two instances share stimulus: LOOP=1 (unit 0) and LOOP=0 (unit 1).
module tb_freq_source_scheduler;

   typedef struct {
      int    u;
      string nm;
      logic  s;
      int    ad;
      int    f1;
      int    f2;
      logic  p;
      logic  chkf;
   } exp_t;

   logic        Clk;
   logic        Reset;
   logic        h_active;
   logic        autoplay_en;
   logic        tick;
   logic [21:0] rd0, rd1;
   logic [5:0]  a0, a1;
   logic        s0, s1, p0, p1;
   logic [10:0] f10, f20, f11, f21;

   exp_t q[$];
   int   checks;
   int   fails;
   int   pf1, pf2;

   freq_source_scheduler #(
      .ADDR_W(6), .SONG_LEN(3), .NOTE_TICKS(2),
      .HOLDOFF_TICKS(2), .LOOP(1)
   ) dut (
      .Clk(Clk), .Reset(Reset), .h_active(h_active),
      .autoplay_en(autoplay_en), .tick(tick), .rom_data(rd0),
      .rom_addr(a0), .select(s0), .c_freq1(f10),
      .c_freq2(f20), .playing(p0)
   );

   freq_source_scheduler #(
      .ADDR_W(6), .SONG_LEN(3), .NOTE_TICKS(2),
      .HOLDOFF_TICKS(2), .LOOP(0)
   ) dut1 (
      .Clk(Clk), .Reset(Reset), .h_active(h_active),
      .autoplay_en(autoplay_en), .tick(tick), .rom_data(rd1),
      .rom_addr(a1), .select(s1), .c_freq1(f11),
      .c_freq2(f21), .playing(p1)
   );

   function automatic logic [21:0] rom(input logic [5:0] a);
      case (a)
         6'd0:    return {11'd100, 11'd200};
         6'd1:    return {11'd300, 11'd400};
         6'd2:    return {11'd500, 11'd600};
         default: return 22'd0;
      endcase
   endfunction

   // synchronous song ROMs, one cycle latency
   always @(posedge Clk) begin
      rd0 <= rom(a0);
      rd1 <= rom(a1);
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // monitor: compare every queued expectation after each edge
   initial begin
      exp_t e;
      logic  gs, gp;
      int    ga, g1, g2;
      logic  bad;
      forever begin
         @(posedge Clk);
         #2;
         while (q.size() > 0) begin
            e  = q.pop_front();
            gs = (e.u == 0) ? s0 : s1;
            gp = (e.u == 0) ? p0 : p1;
            ga = (e.u == 0) ? int'(a0) : int'(a1);
            g1 = (e.u == 0) ? int'(f10) : int'(f11);
            g2 = (e.u == 0) ? int'(f20) : int'(f21);
            bad = (gs !== e.s) || (gp !== e.p) || (ga != e.ad);
            if (e.chkf && (g1 != e.f1 || g2 != e.f2)) bad = 1'b1;
            checks++;
            if (bad) begin
               fails++;
               $display("FAIL %s u%0d: got sel=%0b addr=%0d f=%0d,%0d play=%0b want sel=%0b addr=%0d f=%0d,%0d play=%0b",
                        e.nm, e.u, gs, ga, g1, g2, gp,
                        e.s, e.ad, e.f1, e.f2, e.p);
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic h,
                      input logic a, input logic t);
      @(negedge Clk);
      Reset       = r;
      h_active    = h;
      autoplay_en = a;
      tick        = t;
   endtask

   task automatic ex(input int u, input string nm, input logic s,
                     input int ad, input int f1, input int f2,
                     input logic p, input logic chkf = 1'b1);
      exp_t e;
      e = '{u: u, nm: nm, s: s, ad: ad, f1: f1, f2: f2,
            p: p, chkf: chkf};
      q.push_back(e);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0);
      ex(0, "reset", 0, 0, 0, 0, 0);
      ex(1, "reset", 0, 0, 0, 0, 0);
      pf1 = 0;
      pf2 = 0;
   endtask

   // entry: just entered C_FETCH at address a
   task automatic note(input int a, input int f1, input int f2,
                       input int an, input logic last);
      cyc(0, 0, 1, 0); ex(0, "load", 1, a, pf1, pf2, 0);
      cyc(0, 0, 1, 0); ex(0, "play", 1, a, f1, f2, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1); ex(0, "tick1", 1, a, f1, f2, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0); ex(0, "held", 1, a, f1, f2, 1);
      cyc(0, 0, 1, 1); ex(0, "adv", 1, an, f1, f2, 0);
      if (last) ex(1, "stop", 0, 0, 0, 0, 0);
      pf1 = f1;
      pf2 = f2;
   endtask

   initial begin
      checks      = 0;
      fails       = 0;
      Reset       = 1'b1;
      h_active    = 1'b0;
      autoplay_en = 1'b0;
      tick        = 1'b0;

      // full song: wrap with LOOP=1, stop with LOOP=0
      do_reset();
      cyc(0, 0, 1, 0);
      ex(0, "fetch0", 1, 0, 0, 0, 0);
      ex(1, "fetch0", 1, 0, 0, 0, 0);
      note(0, 100, 200, 1, 0);
      note(1, 300, 400, 2, 0);
      note(2, 500, 600, 0, 1);
      cyc(0, 0, 1, 0);
      ex(0, "wrapload", 1, 0, 500, 600, 0);
      ex(1, "restart", 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      ex(0, "wrapplay", 1, 0, 100, 200, 1);

      // preempt on the final tick, then hold-off restart
      do_reset();
      cyc(0, 0, 1, 0); ex(0, "fetch0", 1, 0, 0, 0, 0);
      note(0, 100, 200, 1, 0);
      cyc(0, 0, 1, 0); ex(0, "load1", 1, 1, 100, 200, 0);
      cyc(0, 0, 1, 0); ex(0, "play1", 1, 1, 300, 400, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 1, 1); ex(0, "preempt", 0, 1, 300, 400, 0);
      cyc(0, 1, 1, 0); ex(0, "human", 0, 1, 300, 400, 0);
      cyc(0, 0, 1, 0); ex(0, "holdoff", 0, 1, 300, 400, 0);
      cyc(0, 0, 1, 1); ex(0, "hold1", 0, 1, 300, 400, 0);
      cyc(0, 1, 1, 0); ex(0, "repress", 0, 1, 300, 400, 0);
      cyc(0, 0, 1, 0); ex(0, "holdoff2", 0, 1, 300, 400, 0);
      cyc(0, 0, 1, 1); ex(0, "holdclr", 0, 1, 300, 400, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1); ex(0, "resume", 1, 1, 300, 400, 0);
      pf1 = 300;
      pf2 = 400;
      note(1, 300, 400, 2, 0);

      // autoplay_en drop in C_PLAY and during hold-off
      do_reset();
      cyc(0, 0, 1, 0); ex(0, "fetch0", 1, 0, 0, 0, 0);
      note(0, 100, 200, 1, 0);
      cyc(0, 0, 1, 0); ex(0, "load1", 1, 1, 100, 200, 0);
      cyc(0, 0, 1, 0); ex(0, "play1", 1, 1, 300, 400, 1);
      cyc(0, 0, 0, 0); ex(0, "dropplay", 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0); ex(0, "refetch", 1, 0, 0, 0, 0);
      pf1 = 0;
      pf2 = 0;
      note(0, 100, 200, 1, 0);
      cyc(0, 1, 1, 0); ex(0, "fpreempt", 0, 1, 100, 200, 0);
      cyc(0, 0, 1, 0); ex(0, "holdoff", 0, 1, 100, 200, 0);
      cyc(0, 0, 0, 1); ex(0, "hodrop", 0, 1, 100, 200, 0);
      cyc(0, 0, 0, 0); ex(0, "hodrop2", 0, 1, 100, 200, 0);
      cyc(0, 0, 0, 1); ex(0, "hoexpire", 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0); ex(0, "fromidle", 1, 0, 0, 0, 0, 0);

      // reset in C_LOAD, then replay from address 0
      do_reset();
      cyc(0, 0, 1, 0); ex(0, "fetch0", 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0); ex(0, "load0", 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0);
      ex(0, "midreset", 0, 0, 0, 0, 0);
      ex(1, "midreset", 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0); ex(0, "rfetch", 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0); ex(0, "rload", 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0); ex(0, "replay", 1, 0, 100, 200, 1);

      cyc(0, 0, 0, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(posedge Clk);
      end
      #3;
      if (q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
